// File: rtl/csidh_job_sequencer_pkg.sv
// Shared types for the CSIDH job sequencer: result status codes and FSM state encodings.
package csidh_job_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_OK            = 2'b00,
        ST_INVALID_CURVE = 2'b01,
        ST_BAD_KEY       = 2'b10,
        ST_TIMEOUT       = 2'b11
    } status_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_RESET = 3'd2,
        S_RUN   = 3'd3,
        S_EMIT  = 3'd4
    } state_e;

endpackage

// File: rtl/csidh_job_sequencer_fifo.sv
// Job FIFO: DEPTH x W storage with occupancy count; read data is combinational from the head entry.
// Latency: a push is visible at the head one cycle later. ready is registered (count < DEPTH).
module csidh_job_sequencer_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         empty,
    output logic         ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;

    always_comb begin
        count_nxt = count + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ready  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
            ready <= (count_nxt < CW'(DEPTH));
        end
    end

    assign pop_dat = mem[rd_ptr];
    assign empty   = (count == '0);

endmodule

// File: rtl/csidh_job_sequencer.sv
// Runs queued CSIDH jobs one at a time: screen key, hold core in reset RST_CYCLES, run until done/timeout, emit.
// Latency push->out_valid = 2 + RST_CYCLES + core latency + 1; in_ready registered, out_ready never reaches it.
module csidh_job_sequencer
    import csidh_job_sequencer_pkg::*;
#(
    parameter int N            = 512,
    parameter int NUM_PRIMES   = 74,
    parameter int EXP_BITS     = 4,
    parameter int MAX_EXP_CODE = 10,
    parameter int DEPTH        = 4,
    parameter int TAG_W        = 8,
    parameter int RST_CYCLES   = 10,
    parameter int TIMEOUT_W    = 32,
    localparam int KEY_W       = NUM_PRIMES * EXP_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         in_a,
    input  logic [KEY_W-1:0]     in_key,
    input  logic [TAG_W-1:0]     in_tag,
    input  logic [TIMEOUT_W-1:0] timeout_cycles,
    output logic                 core_rst,
    output logic [N-1:0]         core_a_in,
    output logic [KEY_W-1:0]     core_private,
    input  logic                 core_done,
    input  logic [N-1:0]         core_a_out,
    input  logic                 core_invalid,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         out_a,
    output logic [TAG_W-1:0]     out_tag,
    output logic [1:0]           out_status,
    output logic                 busy,
    output logic [15:0]          jobs_done
);
    localparam int FW   = N + KEY_W + TAG_W;
    localparam int RC_W = $clog2(RST_CYCLES + 1);

    state_e                state_q, state_d;
    logic                  fifo_push, fifo_pop, fifo_empty;
    logic [FW-1:0]         fifo_dat;
    logic [KEY_W-1:0]      fifo_key;
    logic [NUM_PRIMES-1:0] nib_bad;
    logic                  key_bad, bad_q;
    logic [RC_W-1:0]       rst_cnt_q;
    logic [TIMEOUT_W-1:0]  run_cnt_q, tmo_q;
    logic                  tmo_hit;
    logic [N-1:0]          res_a;
    status_e               res_status;

    csidh_job_sequencer_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (fifo_push),
        .push_dat ({in_a, in_key, in_tag}),
        .pop      (fifo_pop),
        .pop_dat  (fifo_dat),
        .empty    (fifo_empty),
        .ready    (in_ready)
    );

    assign fifo_push = in_valid && in_ready;
    assign fifo_key  = fifo_dat[KEY_W+TAG_W-1 -: KEY_W];

    // Screen the head entry while popping so CHECK only has to act on a flop.
    always_comb begin
        nib_bad = '0;
        for (int i = 0; i < NUM_PRIMES; i++) begin
            nib_bad[i] = fifo_key[i*EXP_BITS +: EXP_BITS] > EXP_BITS'(MAX_EXP_CODE);
        end
    end
    assign key_bad = |nib_bad;

    assign tmo_hit = (tmo_q != '0) && (run_cnt_q + TIMEOUT_W'(1) == tmo_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = S_CHECK;
                end
            end
            S_CHECK: state_d = bad_q ? S_EMIT : S_RESET;
            S_RESET: if (rst_cnt_q == RC_W'(RST_CYCLES - 1)) state_d = S_RUN;
            S_RUN:   if (core_done || tmo_hit) state_d = S_EMIT;
            S_EMIT:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_a_in    <= '0;
            core_private <= '0;
            out_tag      <= '0;
            bad_q        <= 1'b0;
            rst_cnt_q    <= '0;
            run_cnt_q    <= '0;
            tmo_q        <= '0;
            res_a        <= '0;
            res_status   <= ST_OK;
            jobs_done    <= '0;
        end else begin
            // Operands to the core only move here, while the core is held in reset.
            if (fifo_pop) begin
                core_a_in    <= fifo_dat[FW-1 -: N];
                core_private <= fifo_key;
                out_tag      <= fifo_dat[TAG_W-1:0];
                bad_q        <= key_bad;
            end
            case (state_q)
                S_CHECK: begin
                    rst_cnt_q <= '0;
                    if (bad_q) begin
                        res_a      <= '0;
                        res_status <= ST_BAD_KEY;
                    end
                end
                S_RESET: begin
                    rst_cnt_q <= rst_cnt_q + RC_W'(1);
                    run_cnt_q <= '0;
                    if (state_d == S_RUN) tmo_q <= timeout_cycles;
                end
                S_RUN: begin
                    run_cnt_q <= run_cnt_q + TIMEOUT_W'(1);
                    if (core_done) begin
                        res_a      <= core_invalid ? '0 : core_a_out;
                        res_status <= core_invalid ? ST_INVALID_CURVE : ST_OK;
                    end else if (tmo_hit) begin
                        res_a      <= '0;
                        res_status <= ST_TIMEOUT;
                    end
                end
                S_EMIT: if (out_ready) jobs_done <= jobs_done + 16'd1;
                default: ;
            endcase
        end
    end

    assign core_rst   = (state_q != S_RUN);
    assign out_valid  = (state_q == S_EMIT);
    assign out_a      = res_a;
    assign out_status = res_status;
    assign busy       = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_csidh_job_sequencer.sv
// Bench for csidh_job_sequencer: programmable-latency core stub, scoreboard of expected results per job.
module tb_csidh_job_sequencer;
    localparam int N     = 512;
    localparam int KEY_W = 296;
    localparam int TAG_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [N-1:0]     in_a = '0;
    logic [KEY_W-1:0] in_key = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic [31:0]      timeout_cycles = '0;
    logic             core_rst;
    logic [N-1:0]     core_a_in;
    logic [KEY_W-1:0] core_private;
    logic             core_done;
    logic [N-1:0]     core_a_out;
    logic             core_invalid;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [N-1:0]     out_a;
    logic [TAG_W-1:0] out_tag;
    logic [1:0]       out_status;
    logic             busy;
    logic [15:0]      jobs_done;

    csidh_job_sequencer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_key(in_key), .in_tag(in_tag), .timeout_cycles(timeout_cycles),
        .core_rst(core_rst), .core_a_in(core_a_in), .core_private(core_private),
        .core_done(core_done), .core_a_out(core_a_out), .core_invalid(core_invalid),
        .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_tag(out_tag),
        .out_status(out_status), .busy(busy), .jobs_done(jobs_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Core stub: done fires once stub_cnt cycles out of reset reach stub_lat.
    logic [15:0] stub_lat = 16'd50;
    logic        stub_hang = 1'b0;
    logic        stub_invalid = 1'b0;
    logic [15:0] stub_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   stub_cnt <= '0;
        else if (core_rst)            stub_cnt <= '0;
        else if (stub_cnt != 16'hFFFF) stub_cnt <= stub_cnt + 16'd1;
    end
    assign core_done    = !core_rst && !stub_hang && (stub_cnt == stub_lat);
    assign core_invalid = stub_invalid;
    assign core_a_out   = core_a_in + {{(N-KEY_W){1'b0}}, core_private};

    typedef struct {
        logic [N-1:0]     a;
        logic [TAG_W-1:0] tag;
        logic [1:0]       st;
    } exp_t;
    exp_t sb[$];

    int n_cmp = 0;
    int n_fail = 0;
    int exp_jobs = 0;
    int last_push = 0;

    logic             r_ok, r_rst, r_stable;
    logic [N-1:0]     r_a;
    logic [TAG_W-1:0] r_tag;
    logic [1:0]       r_st;
    int               r_lat, r_low, r_rel;

    task automatic push_job(input logic [N-1:0] a, input logic [KEY_W-1:0] key,
                            input logic [TAG_W-1:0] tag, input logic [1:0] st);
        exp_t e;
        int w = 0;
        @(negedge clk);
        while (!in_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        n_cmp++;
        if (!in_ready) begin
            n_fail++;
            $display("FAIL push_wait in_ready got 0 want 1 (tag %0h)", tag);
        end
        in_valid = 1'b1; in_a = a; in_key = key; in_tag = tag;
        last_push = cyc + 1;
        e.a = (st == 2'b00) ? a + {{(N-KEY_W){1'b0}}, key} : '0;
        e.tag = tag;
        e.st = st;
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Waits for a result, recording core_rst activity and output stability, then accepts it.
    task automatic collect(input int start);
        r_ok = 1'b0; r_low = 0; r_rel = -1; r_lat = -1; r_stable = 1'b0; r_rst = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (!core_rst) begin
                if (r_rel < 0) r_rel = cyc - start;
                r_low++;
            end
            if (out_valid) begin
                r_ok = 1'b1;
                break;
            end
        end
        if (r_ok) begin
            r_a = out_a; r_tag = out_tag; r_st = out_status;
            r_lat = cyc - start; r_rst = core_rst;
            r_stable = 1'b1;
            repeat (2) begin
                @(negedge clk);
                if (!out_valid || out_a !== r_a || out_tag !== r_tag || out_status !== r_st || !core_rst)
                    r_stable = 1'b0;
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            exp_jobs++;
        end
    endtask

    task automatic test_reset;
        #3;
        n_cmp++; if (core_rst !== 1'b1) begin n_fail++; $display("FAIL reset_core_rst got %b want 1", core_rst); end
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_valid_busy got %b%b want 00", out_valid, busy); end
        n_cmp++; if (jobs_done !== 16'd0 || core_a_in !== '0 || core_private !== '0) begin n_fail++; $display("FAIL reset_regs jobs_done got %0d want 0", jobs_done); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_after got %b want 1", in_ready); end
    endtask

    task automatic test_single_job;
        logic [KEY_W-1:0] k;
        exp_t e;
        k = '0; k[48 +: 4] = 4'd1;
        stub_lat = 16'd50; timeout_cycles = 32'd0;
        push_job('0, k, 8'h5A, 2'b00);
        collect(last_push);
        e = sb.pop_front();
        n_cmp++; if (!r_ok) begin n_fail++; $display("FAIL single_valid got none want out_valid"); end
        n_cmp++; if (r_st !== e.st) begin n_fail++; $display("FAIL single_status got %0d want %0d", r_st, e.st); end
        n_cmp++; if (r_tag !== e.tag) begin n_fail++; $display("FAIL single_tag got %0h want %0h", r_tag, e.tag); end
        n_cmp++; if (r_a !== e.a) begin n_fail++; $display("FAIL single_a got %0h want %0h", r_a, e.a); end
        n_cmp++; if (r_lat !== 63) begin n_fail++; $display("FAIL single_latency got %0d want 63", r_lat); end
        n_cmp++; if (r_rel !== 12) begin n_fail++; $display("FAIL single_release got %0d want 12", r_rel); end
        n_cmp++; if (r_low !== 51) begin n_fail++; $display("FAIL single_run_cycles got %0d want 51", r_low); end
        n_cmp++; if (r_rst !== 1'b1 || !r_stable) begin n_fail++; $display("FAIL single_emit got rst=%b stable=%b want 1 1", r_rst, r_stable); end
        n_cmp++; if (jobs_done !== 16'(exp_jobs)) begin n_fail++; $display("FAIL single_jobs_done got %0d want %0d", jobs_done, exp_jobs); end
    endtask

    task automatic test_bad_key;
        logic [KEY_W-1:0] kb, kg;
        exp_t e;
        kb = '0; kb[12 +: 4] = 4'hB;
        kg = '0; kg[0 +: 4] = 4'd10; kg[292 +: 4] = 4'd3;
        stub_lat = 16'd5;
        push_job(512'h1234, kb, 8'h21, 2'b10);
        push_job(512'h777, kg, 8'h22, 2'b00);
        collect(last_push);
        e = sb.pop_front();
        n_cmp++; if (!r_ok || r_st !== e.st) begin n_fail++; $display("FAIL badkey_status got %0d want %0d", r_st, e.st); end
        n_cmp++; if (r_a !== e.a || r_tag !== e.tag) begin n_fail++; $display("FAIL badkey_a_tag got %0h/%0h want %0h/%0h", r_a, r_tag, e.a, e.tag); end
        n_cmp++; if (r_low !== 0) begin n_fail++; $display("FAIL badkey_core_released got %0d cycles want 0", r_low); end
        collect(last_push);
        e = sb.pop_front();
        n_cmp++; if (!r_ok || r_st !== e.st || r_tag !== e.tag) begin n_fail++; $display("FAIL badkey_next_job got st=%0d tag=%0h want st=%0d tag=%0h", r_st, r_tag, e.st, e.tag); end
        n_cmp++; if (r_a !== e.a) begin n_fail++; $display("FAIL badkey_next_a got %0h want %0h", r_a, e.a); end
    endtask

    task automatic test_timeout;
        exp_t e;
        stub_hang = 1'b1; timeout_cycles = 32'd20;
        push_job(512'hABCDEF, '0, 8'h33, 2'b11);
        // Lowering the limit mid-RUN must not shorten the sampled timeout.
        fork
            collect(last_push);
            begin
                repeat (20) @(negedge clk);
                timeout_cycles = 32'd3;
            end
        join
        e = sb.pop_front();
        n_cmp++; if (!r_ok || r_st !== e.st) begin n_fail++; $display("FAIL timeout_status got %0d want %0d", r_st, e.st); end
        n_cmp++; if (r_a !== e.a) begin n_fail++; $display("FAIL timeout_a got %0h want 0", r_a); end
        n_cmp++; if (r_low !== 20) begin n_fail++; $display("FAIL timeout_run_cycles got %0d want 20", r_low); end
        n_cmp++; if (r_lat !== 32) begin n_fail++; $display("FAIL timeout_latency got %0d want 32", r_lat); end
        n_cmp++; if (r_rst !== 1'b1) begin n_fail++; $display("FAIL timeout_emit_rst got %b want 1", r_rst); end
        stub_hang = 1'b0; timeout_cycles = 32'd0;
    endtask

    task automatic test_invalid_curve;
        logic [KEY_W-1:0] k;
        exp_t e;
        k = '0; k[100 +: 4] = 4'd7;
        stub_invalid = 1'b1; stub_lat = 16'd8;
        push_job(512'h99, k, 8'h44, 2'b01);
        collect(last_push);
        e = sb.pop_front();
        n_cmp++; if (!r_ok || r_st !== e.st) begin n_fail++; $display("FAIL invalid_status got %0d want %0d", r_st, e.st); end
        n_cmp++; if (r_a !== e.a) begin n_fail++; $display("FAIL invalid_a got %0h want 0", r_a); end
        stub_invalid = 1'b0; stub_lat = 16'd19; timeout_cycles = 32'd20;
        push_job(512'h5555, k, 8'h45, 2'b00);
        collect(last_push);
        e = sb.pop_front();
        n_cmp++; if (!r_ok || r_st !== e.st) begin n_fail++; $display("FAIL done_vs_timeout_status got %0d want %0d", r_st, e.st); end
        n_cmp++; if (r_a !== e.a || r_low !== 20) begin n_fail++; $display("FAIL done_vs_timeout_a got %0h run=%0d want %0h run=20", r_a, r_low, e.a); end
        timeout_cycles = 32'd0;
    endtask

    task automatic test_backpressure;
        logic [KEY_W-1:0] k;
        exp_t e;
        stub_lat = 16'd3;
        for (int i = 0; i < 5; i++) begin
            k = '0;
            k[i*4 +: 4] = 4'(i + 1);
            if (i == 2) k[280 +: 4] = 4'hF;
            push_job(N'(i * 1000 + 7), k, 8'(8'h40 + i), (i == 2) ? 2'b10 : 2'b00);
        end
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_full got %b want 0", in_ready); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_busy got %b want 1", busy); end
        for (int i = 0; i < 5; i++) begin
            collect(last_push);
            e = sb.pop_front();
            n_cmp++;
            if (!r_ok || r_tag !== e.tag || r_st !== e.st || r_a !== e.a || !r_stable) begin
                n_fail++;
                $display("FAIL bp_result%0d got tag=%0h st=%0d a=%0h want tag=%0h st=%0d a=%0h", i, r_tag, r_st, r_a, e.tag, e.st, e.a);
            end
        end
        n_cmp++; if (jobs_done !== 16'(exp_jobs)) begin n_fail++; $display("FAIL bp_jobs_done got %0d want %0d", jobs_done, exp_jobs); end
    endtask

    task automatic test_async_reset;
        logic [KEY_W-1:0] k;
        logic clean;
        int w = 0;
        exp_t e;
        k = '0; k[8 +: 4] = 4'd2;
        stub_hang = 1'b1;
        push_job(512'h1, k, 8'h61, 2'b00);
        push_job(512'h2, k, 8'h62, 2'b00);
        while (core_rst && w < 100) begin
            @(negedge clk);
            w++;
        end
        n_cmp++; if (core_rst !== 1'b0) begin n_fail++; $display("FAIL arst_reach_run core_rst got %b want 0", core_rst); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (core_rst !== 1'b1) begin n_fail++; $display("FAIL arst_core_rst got %b want 1", core_rst); end
        n_cmp++; if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_flags got busy=%b rdy=%b vld=%b want 000", busy, in_ready, out_valid); end
        n_cmp++; if (jobs_done !== 16'd0 || core_a_in !== '0 || out_status !== 2'b00) begin n_fail++; $display("FAIL arst_regs got jobs_done=%0d want 0", jobs_done); end
        sb.delete();
        exp_jobs = 0;
        stub_hang = 1'b0; stub_lat = 16'd3;
        @(negedge clk);
        rst_n = 1'b1;
        clean = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (busy || out_valid || !core_rst) clean = 1'b0;
        end
        n_cmp++; if (!clean) begin n_fail++; $display("FAIL arst_fifo_flushed got activity want idle"); end
        push_job(512'h3, k, 8'h63, 2'b00);
        collect(last_push);
        e = sb.pop_front();
        n_cmp++; if (!r_ok || r_tag !== e.tag || r_a !== e.a || r_lat !== 16) begin n_fail++; $display("FAIL arst_after got tag=%0h lat=%0d want tag=%0h lat=16", r_tag, r_lat, e.tag); end
        n_cmp++; if (jobs_done !== 16'(exp_jobs)) begin n_fail++; $display("FAIL arst_jobs_done got %0d want %0d", jobs_done, exp_jobs); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_job();
        test_bad_key();
        test_timeout();
        test_invalid_curve();
        test_backpressure();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
